// File: rtl/bus_pkg.sv
// Shared types for the valid/addr/wdata -> rdata/ready point-to-point bus.
// Both initiator-side and responder-side blocks import this package.
package bus_pkg;

  localparam int BUS_ADDR_W = 4;
  localparam int BUS_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_resp_state_t;

  // Capture register for one request; its widths follow the package defaults.
  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_resp_regfile.sv
// DEPTH x DATA_W register file for bus_responder: one combinational read port
// with an in-range flag, and one synchronous write port.
module bus_resp_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the entries are cleared by reset on purpose (software reads 0 from
  // any register after reset), which costs a reset on every flop of storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      // NOTE: state uses non-blocking assignments so every flop samples
      // pre-edge values, regardless of statement order.
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // Decoding only implemented indices makes unmapped addresses read 0 and miss.
  always_comb begin
    // NOTE: defaults first so no path leaves rdata/hit unassigned (no latch).
    rdata = '0;
    hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = mem[i];
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Sequential bus target: register file with WAIT_CYCLES wait states and a
// one-cycle ready pulse. Define BUS_RESP_ERR_EN to add the `err` output.
module bus_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy
`ifdef BUS_RESP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  bus_resp_state_t   state, next_state;
  bus_req_t          req;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lookup_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic              hit;
  logic              we;

  // In IDLE the live address is looked up so a zero-wait transfer can
  // register its response on the same edge that captures the request.
  assign lookup_addr = (state == IDLE) ? addr : req.addr;
  assign we          = (state == RESP) && req.write && hit;

  bus_resp_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clock(clock),
    .reset(reset),
    .raddr(lookup_addr),
    .rdata(rf_rdata),
    .hit  (hit),
    .we   (we),
    .waddr(req.addr),
    .wdata(req.wdata)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && valid) begin
        req <= '{write: write, addr: addr, wdata: wdata};
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Read-before-write: the response is taken before the RESP-ending commit.
      if (next_state == RESP) rdata <= rf_rdata;
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

`ifdef BUS_RESP_ERR_EN
  assign err = (state == RESP) && !hit;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: dut_a (DEPTH 8, 2 wait states) and
// dut_b (DEPTH 16, no wait states) driven by a simple initiator model.
module tb_bus_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       valid_a = 1'b0, write_a = 1'b0;
  logic [3:0] addr_a = '0, wdata_a = '0;
  logic [3:0] rdata_a;
  logic       ready_a, busy_a;
  logic       valid_b = 1'b0, write_b = 1'b0;
  logic [3:0] addr_b = '0, wdata_b = '0;
  logic [3:0] rdata_b;
  logic       ready_b, busy_b;
`ifdef BUS_RESP_ERR_EN
  logic       err_a, err_b;
`endif

  bus_responder #(.ADDR_W(4), .DATA_W(4), .DEPTH(8), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .valid(valid_a), .write(write_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a),
    .busy(busy_a)
`ifdef BUS_RESP_ERR_EN
    , .err(err_a)
`endif
  );

  bus_responder #(.ADDR_W(4), .DATA_W(4), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .valid(valid_b), .write(write_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
    .busy(busy_b)
`ifdef BUS_RESP_ERR_EN
    , .err(err_b)
`endif
  );

  logic [3:0] model_a [16];
  logic [3:0] model_b [16];
  logic [3:0] exp_a [$];
  logic [3:0] exp_b [$];
  bit         err_exp_a [$];
  bit         err_exp_b [$];
  logic [3:0] last_a = '0, last_b = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Response monitor: pops the scoreboard on every ready pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (ready_a) begin
        if (exp_a.size() == 0) check("a_spurious_ready", 1, 0);
        else begin
          last_a = exp_a.pop_front();
          check("a_rdata", rdata_a, last_a);
`ifdef BUS_RESP_ERR_EN
          check("a_err", err_a, err_exp_a.pop_front());
`endif
        end
      end else begin
        check("a_rdata_hold", rdata_a, last_a);
`ifdef BUS_RESP_ERR_EN
        check("a_err_idle", err_a, 0);
`endif
      end
      if (ready_b) begin
        if (exp_b.size() == 0) check("b_spurious_ready", 1, 0);
        else begin
          last_b = exp_b.pop_front();
          check("b_rdata", rdata_b, last_b);
`ifdef BUS_RESP_ERR_EN
          check("b_err", err_b, err_exp_b.pop_front());
`endif
        end
      end else begin
        check("b_rdata_hold", rdata_b, last_b);
`ifdef BUS_RESP_ERR_EN
        check("b_err_idle", err_b, 0);
`endif
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    exp_a.delete(); exp_b.delete();
    err_exp_a.delete(); err_exp_b.delete();
    last_a = '0;
    last_b = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rdata", rdata_a, 0);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // Drive one request at the start of an IDLE cycle and push its expectation.
  task automatic issue(input bit sel, input bit wr, input logic [3:0] a, input logic [3:0] d);
    logic [3:0] e;
    if (!sel) begin
      e = (a < 4'd8) ? model_a[a] : 4'h0;
      if (wr && a < 4'd8) model_a[a] = d;
      exp_a.push_back(e);
      err_exp_a.push_back(a >= 4'd8);
      valid_a = 1'b1; write_a = wr; addr_a = a; wdata_a = d;
    end else begin
      e = model_b[a];
      if (wr) model_b[a] = d;
      exp_b.push_back(e);
      err_exp_b.push_back(1'b0);
      valid_b = 1'b1; write_b = wr; addr_b = a; wdata_b = d;
    end
  endtask

  // Wait (bounded) for ready; n counts cycles since the sampling IDLE cycle.
  task automatic complete(input bit sel, input int exp_lat, input int n0);
    int    n;
    logic  rdy, bsy;
    string p;
    p = sel ? "b" : "a";
    for (n = n0; n <= exp_lat + 4; n++) begin
      @(negedge clock);
      rdy = sel ? ready_b : ready_a;
      bsy = sel ? busy_b : busy_a;
      check({p, "_busy"}, bsy, n != 0);
      if (rdy) break;
    end
    check({p, "_latency"}, n, exp_lat);
    @(posedge clock); #1;
  endtask

  task automatic xfer(input bit sel, input bit wr, input logic [3:0] a, input logic [3:0] d);
    issue(sel, wr, a, d);
    complete(sel, sel ? 1 : 3, 0);
    if (sel) valid_b = 1'b0;
    else valid_a = 1'b0;
  endtask

  initial begin
    do_reset();

    // Read after reset, then write/read with read-before-write response.
    xfer(0, 0, 4'h3, 4'h0);
    xfer(0, 1, 4'h5, 4'hc);
    xfer(0, 0, 4'h5, 4'h0);
    xfer(0, 1, 4'h5, 4'h3);
    xfer(0, 0, 4'h5, 4'h0);

    // Request fields changed during WAIT must be ignored.
    issue(0, 1, 4'h6, 4'h9);
    @(posedge clock); #1;
    addr_a = 4'h7;
    wdata_a = 4'h1;
    complete(0, 3, 1);
    valid_a = 1'b0;
    xfer(0, 0, 4'h6, 4'h0);
    xfer(0, 0, 4'h7, 4'h0);

    // Unmapped write on DEPTH 8: discarded, no aliasing onto entry 2.
    xfer(0, 1, 4'h2, 4'h4);
    xfer(0, 1, 4'ha, 4'hf);
    xfer(0, 0, 4'h2, 4'h0);
    xfer(0, 0, 4'ha, 4'h0);

    // Zero-wait back-to-back writes with valid held: ready on cycles 1, 3, 5.
    issue(1, 1, 4'h1, 4'h4); complete(1, 1, 0);
    issue(1, 1, 4'h2, 4'h5); complete(1, 1, 0);
    issue(1, 1, 4'h3, 4'h6); complete(1, 1, 0);
    valid_b = 1'b0;
    for (int i = 0; i < 4; i++) xfer(1, 0, 4'(i), 4'h0);

    for (int i = 0; i < 10; i++) begin
      xfer(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      xfer(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset during WAIT of a write: nothing committed, next request works.
    issue(0, 1, 4'h2, 4'h5);
    @(posedge clock); #1;
    check("a_busy_in_wait", busy_a, 1);
    do_reset();
    xfer(0, 0, 4'h2, 4'h0);
    xfer(0, 1, 4'h2, 4'h3);
    xfer(0, 0, 4'h2, 4'h0);
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
